uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  Receives 8-bit async serial frames (LSB first, 1 start, 1 stop) on the top-level uart_rx pin.
//  Complements the uart_tx direction of the board UART.
//  Oversamples the line, validates start and stop bits, and buffers bytes in a small FIFO.
//  A later dmem-mapped peripheral drains the FIFO through a valid/ready pop interface.
// PARAMETERS
//  CLK_FREQ    50_000_000  core clock in Hz
//  BAUD        115200      line rate in bit/s
//  OVERSAMPLE  16          ticks per bit, even, >=8
//  FIFO_DEPTH  8           receive buffer entries, power of 2
//  PARITY_ODD  0           0=even, 1=odd; used only with UART_RX_PARITY_EN
// PORTS
//  clk            in   1   core clock
//  reset          in   1   reset, synchronous, active-high
//  uart_rx        in   1   async serial line, idle high
//  rx_data        out  8   FIFO head byte; valid only while rx_valid
//  rx_valid       out  1   FIFO not empty
//  rx_ready       in   1   pop head when rx_valid&rx_ready
//  fifo_count     out  $clog2(FIFO_DEPTH+1)  bytes held
//  rx_overrun     out  1   sticky: byte dropped because FIFO full
//  rx_frame_err   out  1   sticky: stop bit sampled 0
//  rx_parity_err  out  1   sticky: parity mismatch; tied 0 without macro
//  err_clear      in   1   clears all sticky flags
// BEHAVIOUR
//  - Reset: rx_valid=0, fifo_count=0, rx_data=0, all flags=0, FSM=IDLE, sync flops=1.
//  - Input: uart_rx passes through a 2-flop synchronizer. All decisions use the synced value.
//  - Tick counter: one tick every CLKS_PER_TICK=round(CLK_FREQ/(BAUD*OVERSAMPLE)) clks, min 1.
//    Counter restarts on IDLE->START.
//  - Sample point: each bit is sampled at tick OVERSAMPLE/2-1 of that bit (mid-bit).
//  - IDLE -> START: on synced line = 0.
//  - START at mid-bit: line 1 -> IDLE (glitch rejected, nothing recorded); line 0 -> DATA.
//  - DATA: 8 mid-bit samples shifted in LSB first -> PARITY (macro on) or STOP.
//  - STOP at mid-bit:
//    - 1: push byte -> IDLE. A new start bit is accepted from the next clk.
//    - 0: set rx_frame_err, discard byte -> BREAK.
//  - BREAK -> IDLE: once synced line = 1.
//  - Latency: rx_valid rises 1 clk after the stop-bit mid sample when FIFO was empty.
//  - FIFO: first-word fall-through. rx_data = head.
//    - Push while full with no pop: byte dropped, rx_overrun set.
//    - Push+pop same clk while full: both happen; count unchanged, no overrun.
//    - Pop when empty: ignored.
//    - Pointers wrap modulo FIFO_DEPTH.
//  - Sticky flags: set has priority over err_clear in the same clk.
//  - Reset mid-frame: frame abandoned, all state back to reset values.
//    The next full frame is received correctly.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    - PARITY state between DATA and STOP samples one parity bit, checked per PARITY_ODD.
//    - On mismatch: rx_parity_err set, byte discarded; the stop bit is still checked.
//  - Not defined: no PARITY state; 8N1 only; rx_parity_err constant 0.
// STRUCTURE
//  - uart_pkg holds:
//    - rx_state_t enum {IDLE, START, DATA, PARITY, STOP, BREAK}
//    - UART_DATA_BITS=8
//    - function clks_per_tick(freq, baud, os)
//  - Sub-module uart_rx_fifo: sync FWFT FIFO with push/pop/count/full/empty.
//    Reusable later by the transmit path.
//  - Top of this module: synchronizer, tick generator, FSM, shift register, flags.
// TESTING (CLK_FREQ=1_843_200, BAUD=115200 -> 1 clk/tick, 16 clk/bit)
//  1 Send 0xA5 8N1, rx_ready=0 -> rx_valid=1 at 1 clk after stop mid; rx_data=0xA5; fifo_count=1.
//  2 Drive uart_rx low 4 clks, then high -> no push; FSM back in IDLE; flags 0.
//  3 Send 0x3C with stop bit 0 -> rx_frame_err=1, fifo_count=0.
//    Pulse err_clear -> flag 0. Next frame 0x11 received.
//  4 rx_ready=0, send 9 bytes 0x00..0x08 (depth 8) -> fifo_count=8, rx_overrun=1.
//    Draining yields 0x00..0x07 in order.
//  5 Assert reset after 4 data bits of 0xFF -> outputs at reset values.
//    Next frame 0x5A -> rx_data=0x5A.
//  6 With UART_RX_PARITY_EN, even: send 0x07 with parity bit 0 -> rx_parity_err=1, no push.
//    Send 0x07 with parity 1 -> byte 0x07 received.
//    Without macro -> rx_parity_err stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, data width, baud tick divisor.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int unsigned clks_per_tick(input int unsigned freq,
                                                input int unsigned baud,
                                                input int unsigned os);
    int unsigned div;
    int unsigned quo;
    div = baud * os;
    quo = (freq + div / 2) / div;
    return (quo == 0) ? 1 : quo;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO; head is visible on data_o while not empty.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o,
  output logic                           full_o,
  output logic                           empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push while full still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_receiver.sv
// Oversampling 8-bit UART receiver with start/stop validation and a FWFT receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit between data and stop (PARITY_ODD selects sense).
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              uart_rx,
  output logic [UART_DATA_BITS-1:0]         rx_data,
  output logic                              rx_valid,
  input  logic                              rx_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
  output logic                              rx_overrun,
  output logic                              rx_frame_err,
  output logic                              rx_parity_err,
  input  logic                              err_clear
);

  localparam int unsigned CPT = clks_per_tick(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int unsigned TW  = (CPT > 1) ? $clog2(CPT) : 1;
  localparam int unsigned OW  = $clog2(OVERSAMPLE);
  localparam int unsigned BW  = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(CPT - 1);
  localparam logic [OW-1:0] OS_MID    = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(UART_DATA_BITS - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  rx_state_t                 state_q, state_d;
  logic [TW-1:0]             tick_cnt_q, tick_cnt_d;
  logic [OW-1:0]             os_cnt_q, os_cnt_d;
  logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      overrun_q, overrun_d;
  logic                      frame_err_q, frame_err_d;
  logic                      tick, sample;
  logic                      push, pop, fifo_full, fifo_empty;
  logic                      set_frame;

`ifdef UART_RX_PARITY_EN
  localparam logic PAR_ODD = (PARITY_ODD != 0);
  logic par_bad_q, par_bad_d;
  logic parity_err_q, parity_err_d;
  logic set_parity;
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  assign rx_s   = sync_q[1];
  assign tick   = (tick_cnt_q == TICK_LAST);
  // The oversample counter wraps once per bit, so mid-bit recurs every OVERSAMPLE ticks.
  assign sample = tick && (os_cnt_q == OS_MID);
  assign pop    = rx_ready && rx_valid;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    set_frame  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    set_parity = 1'b0;
`endif
    if (tick) os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OW'(1);

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        os_cnt_d   = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (sample) state_d = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (sample) begin
          shift_d   = {rx_s, shift_q[UART_DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (sample) begin
          par_bad_d  = ((^shift_q) ^ rx_s) != PAR_ODD;
          set_parity = par_bad_d;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        if (sample) begin
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push = !par_bad_q;
`else
            push = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            set_frame = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    overrun_d   = (push && fifo_full && !pop) ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
    frame_err_d = set_frame ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
`ifdef UART_RX_PARITY_EN
    parity_err_d = set_parity ? 1'b1 : (err_clear ? 1'b0 : parity_err_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q      <= {sync_q[0], uart_rx};
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (pop),
    .data_o  (rx_data),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx_valid     = !fifo_empty;
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver at 1 clk/tick, 16 clk/bit: frame-level queue model plus directed timing cases.
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int unsigned CLK_FREQ = 1_843_200;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned OS       = 16;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned PAR_ODD  = 0;
  localparam int unsigned CW       = $clog2(DEPTH + 1);
  localparam int          BIT_CLKS = CLK_FREQ / BAUD;
  // Stop-bit mid sample lands 2 sync clks + half a bit after the stop bit is driven.
  localparam int          TO_MID   = BIT_CLKS / 2 + 2;
  localparam int          GAP      = 20;

  logic          clk = 1'b0;
  logic          reset, uart_rx, rx_ready, err_clear;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [CW-1:0] fifo_count;
  logic          rx_overrun, rx_frame_err, rx_parity_err;

  int checks = 0;
  int errors = 0;

  logic [7:0] mq[$];
  logic       m_over, m_frame, m_par;

  typedef struct {
    logic [7:0]  data;
    logic        stop;
    int unsigned exp_count;
    logic        exp_frame;
    logic [7:0]  exp_head;
  } vec_t;
  vec_t vt[6];

  always #5 clk = ~clk;

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (PAR_ODD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .uart_rx       (uart_rx),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .fifo_count    (fifo_count),
    .rx_overrun    (rx_overrun),
    .rx_frame_err  (rx_frame_err),
    .rx_parity_err (rx_parity_err),
    .err_clear     (err_clear)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic good_par(input logic [7:0] d);
    return (^d) ^ (PAR_ODD != 0);
  endfunction

  task automatic drive_bit(input logic b);
    uart_rx = b;
    tick(BIT_CLKS);
  endtask

  // Drives start, data, optional parity, then the stop level; returns in the cycle of the stop mid sample.
  task automatic drive_to_stop(input logic [7:0] d, input logic par, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par !== par) $display("unreachable");
`endif
    uart_rx = stop;
    tick(TO_MID);
  endtask

  task automatic finish_frame(input int used);
    tick(BIT_CLKS - TO_MID - used);
    uart_rx = 1'b1;
    tick(GAP);
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop, input logic par_ok);
    if (!stop) m_frame = 1'b1;
    else if (par_ok) begin
      if (mq.size() == DEPTH) m_over = 1'b1;
      else mq.push_back(d);
    end
    if (!par_ok) m_par = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_good);
    logic par;
    logic par_ok;
    par = par_good ? good_par(d) : ~good_par(d);
`ifdef UART_RX_PARITY_EN
    par_ok = par_good;
`else
    par_ok = 1'b1;
`endif
    drive_to_stop(d, par, stop);
    finish_frame(0);
    model_frame(d, stop, par_ok);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count), mq.size());
    check({tag, "_valid"}, rx_valid, mq.size() != 0);
    if (mq.size() != 0) check({tag, "_head"}, rx_data, mq[0]);
    check({tag, "_overrun"}, rx_overrun, m_over);
    check({tag, "_frame"}, rx_frame_err, m_frame);
    check({tag, "_parity"}, rx_parity_err, m_par);
  endtask

  task automatic pop_one();
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic drain_check(input string tag);
    int n;
    n = mq.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, rx_data, mq[0]);
      pop_one();
    end
    check({tag, "_empty"}, rx_valid, 1'b0);
  endtask

  task automatic clear_flags();
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
  endtask

  initial begin
    reset = 1'b1; uart_rx = 1'b1; rx_ready = 1'b0; err_clear = 1'b0;
    m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
    vt[0] = '{8'hA5, 1'b1, 1, 1'b0, 8'hA5};
    vt[1] = '{8'h3C, 1'b0, 1, 1'b1, 8'hA5};
    vt[2] = '{8'h11, 1'b1, 2, 1'b1, 8'hA5};
    vt[3] = '{8'hFF, 1'b1, 3, 1'b1, 8'hA5};
    vt[4] = '{8'h00, 1'b1, 4, 1'b1, 8'hA5};
    vt[5] = '{8'h80, 1'b0, 4, 1'b1, 8'hA5};

    tick(3);
    check("rst_valid", rx_valid, 1'b0);
    check("rst_count", 32'(fifo_count), 0);
    check("rst_data", rx_data, 8'h00);
    check("rst_overrun", rx_overrun, 1'b0);
    check("rst_frame", rx_frame_err, 1'b0);
    check("rst_parity", rx_parity_err, 1'b0);
    reset = 1'b0;
    tick(5);

    // rx_valid rises exactly one clk after the stop-bit mid sample
    drive_to_stop(8'hA5, good_par(8'hA5), 1'b1);
    check("lat_before", rx_valid, 1'b0);
    tick(1);
    check("lat_valid", rx_valid, 1'b1);
    check("lat_data", rx_data, 8'hA5);
    check("lat_count", 32'(fifo_count), 1);
    finish_frame(1);
    model_frame(8'hA5, 1'b1, 1'b1);
    drain_check("t1");
    pop_one();
    check("pop_empty_count", 32'(fifo_count), 0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i].data, vt[i].stop, 1'b1);
      check($sformatf("vec%0d_count", i), 32'(fifo_count), vt[i].exp_count);
      check($sformatf("vec%0d_frame", i), rx_frame_err, vt[i].exp_frame);
      check($sformatf("vec%0d_head", i), rx_data, vt[i].exp_head);
    end
    clear_flags();
    check("clr_frame", rx_frame_err, 1'b0);
    drain_check("vec");

    // flag set wins over a simultaneous err_clear
    err_clear = 1'b1;
    drive_to_stop(8'h3C, good_par(8'h3C), 1'b0);
    check("prio_before", rx_frame_err, 1'b0);
    tick(1);
    check("prio_set", rx_frame_err, 1'b1);
    err_clear = 1'b0;
    finish_frame(1);
    model_frame(8'h3C, 1'b0, 1'b1);
    check_state("prio_after");
    clear_flags();
    send_frame(8'h11, 1'b1, 1'b1);
    check_state("after_ferr");
    drain_check("after_ferr");

    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(40);
    check_state("glitch");
    send_frame(8'h69, 1'b1, 1'b1);
    check_state("post_glitch");
    drain_check("post_glitch");

    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b1);
    check_state("overrun");
    drain_check("overrun");
    clear_flags();

    // push and pop in the same clk while full: no overrun, count unchanged
    for (int i = 0; i < 8; i++) send_frame(8'($urandom), 1'b1, 1'b1);
    drive_to_stop(8'hE7, good_par(8'hE7), 1'b1);
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    void'(mq.pop_front());
    model_frame(8'hE7, 1'b1, 1'b1);
    finish_frame(1);
    check_state("full_pushpop");
    drain_check("full_pushpop");

    for (int n = 0; n < 15; n++) begin
      logic [7:0] d;
      logic stop, pg;
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      pg = ($urandom_range(0, 4) != 0);
      send_frame(d, stop, pg);
      check_state($sformatf("rnd%0d", n));
      repeat ($urandom_range(0, 2)) pop_one();
      if ($urandom_range(0, 5) == 0) clear_flags();
    end

    send_frame(8'hC3, 1'b1, 1'b1);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    reset = 1'b1;
    uart_rx = 1'b1;
    tick(2);
    reset = 1'b0;
    mq.delete();
    m_over = 1'b0; m_frame = 1'b0; m_par = 1'b0;
    check("midrst_data", rx_data, 8'h00);
    check_state("midrst");
    tick(3);
    send_frame(8'h5A, 1'b1, 1'b1);
    check("midrst_5a", rx_data, 8'h5A);
    check_state("midrst_next");
    drain_check("midrst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    check("par_bad_flag", rx_parity_err, 1'b1);
    check_state("par_bad");
    clear_flags();
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_good_data", rx_data, 8'h07);
    check_state("par_good");
`else
    send_frame(8'h07, 1'b1, 1'b1);
    check("par_off_flag", rx_parity_err, 1'b0);
    check_state("par_off");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
